// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: answers CMD0/CMD55/ACMD41/CMD17 and streams
// one 512-byte block fetched byte-by-byte from a MasterCLK-side memory port.
module sd_spi_responder #(
  parameter int INIT_RETRIES = 3,
  parameter int READ_GAP     = 2
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        SPI_CLK,
  input  logic        SPI_CS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        ReadReq,
  output logic [31:0] ReadAddr,
  output logic [8:0]  ReadIndex,
  input  logic [7:0]  ReadData,
  output logic        CardReady
);

  typedef enum logic [2:0] {
    S_CMD_RX, S_NCR, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_q, sclk_d;        // SPI_CLK sync (2 flops) + edge-detect flop
  logic [1:0]  cs_q, cs_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  frame_q, frame_d;      // 0: hunting for start byte, 1..4: arg, 5: CRC
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  r1_q, r1_d;
  logic [8:0]  cnt_q, cnt_d;          // gap / data / crc byte counter
  logic        ready_q, ready_d;
  logic        app_q, app_d;
  logic [7:0]  retry_q, retry_d;
  logic        req_q, req_d;
  logic [8:0]  index_q, index_d;
  logic [31:0] addr_q, addr_d;
  logic        fetch_q, fetch_d;      // ReadReq delayed one cycle; ReadData valid next
  logic [7:0]  buf_q, buf_d;

  logic       rise, fall, cs_active;
  logic [7:0] rx_byte;

  assign rise      = sclk_q[1] & ~sclk_q[2];
  assign fall      = ~sclk_q[1] & sclk_q[2];
  assign cs_active = ~cs_q[1];
  assign rx_byte   = {rx_q[6:0], mosi_q[1]};

  assign SPI_MISO  = miso_q;
  assign ReadReq   = req_q;
  assign ReadAddr  = addr_q;
  assign ReadIndex = index_q;
  assign CardReady = ready_q;

  // Bit engine, frame collection, command decode and response sequencing
  always_comb begin
    state_d = state_q;
    sclk_d  = {sclk_q[1:0], SPI_CLK};
    cs_d    = {cs_q[0], SPI_CS};
    mosi_d  = {mosi_q[0], SPI_MOSI};
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    r1_d    = r1_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    app_d   = app_q;
    retry_d = retry_q;
    req_d   = 1'b0;
    index_d = index_q;
    addr_d  = addr_q;
    fetch_d = req_q;
    buf_d   = fetch_q ? ReadData : buf_q;

    if (!cs_active) begin
      bit_d   = '0;
      miso_d  = 1'b1;
      tx_d    = 8'hFF;
      state_d = S_CMD_RX;
      frame_d = '0;
    end else if (rise) begin
      rx_d  = rx_byte;
      bit_d = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        // Byte boundary: pick the next TX byte; its MSB goes out on the next fall.
        tx_d = 8'hFF;
        case (state_q)
          S_CMD_RX: begin
            if (frame_q == 3'd0) begin
              if (rx_byte[7:6] == 2'b01) begin
                cmd_d   = rx_byte[5:0];
                frame_d = 3'd1;
              end
            end else if (frame_q != 3'd5) begin
              arg_d   = {arg_q[23:0], rx_byte};
              frame_d = frame_q + 3'd1;
            end else begin
              // CRC byte ends the frame; it is not checked.
              frame_d = '0;
              state_d = S_NCR;
              app_d   = 1'b0;
              if (cmd_q == 6'd0) begin
                r1_d    = 8'h01;
                ready_d = 1'b0;
                retry_d = '0;
              end else if (cmd_q == 6'd55) begin
                r1_d  = ready_q ? 8'h00 : 8'h01;
                app_d = 1'b1;
              end else if (cmd_q == 6'd41 && app_q) begin
                if (retry_q < 8'(INIT_RETRIES)) begin
                  r1_d    = 8'h01;
                  retry_d = retry_q + 8'd1;
                end else begin
                  r1_d    = 8'h00;
                  ready_d = 1'b1;
                end
              end else if (cmd_q == 6'd17) begin
                addr_d = arg_q;
                r1_d   = ready_q ? 8'h00 : 8'h05;
              end else begin
                r1_d = 8'h04 | {7'b0, ~ready_q};
              end
            end
          end
          S_NCR: begin
            state_d = S_R1;
            tx_d    = r1_q;
          end
          S_R1: begin
            cnt_d = '0;
            if (cmd_q == 6'd17 && r1_q == 8'h00) begin
              if (READ_GAP == 0) begin
                state_d = S_TOKEN;
                tx_d    = 8'hFE;
                req_d   = 1'b1;
                index_d = '0;
              end else begin
                state_d = S_GAP;
              end
            end else begin
              state_d = S_CMD_RX;
            end
          end
          S_GAP: begin
            if (cnt_q == 9'(READ_GAP - 1)) begin
              state_d = S_TOKEN;
              tx_d    = 8'hFE;
              req_d   = 1'b1;
              index_d = '0;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          S_TOKEN: begin
            state_d = S_DATA;
            tx_d    = buf_q;
            cnt_d   = '0;
            req_d   = 1'b1;
            index_d = 9'd1;
          end
          S_DATA: begin
            if (cnt_q == 9'd511) begin
              state_d = S_CRC;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 9'd1;
              tx_d  = buf_q;
              // Prefetch one byte ahead; the last byte needs no successor.
              if (cnt_q != 9'd510) begin
                req_d   = 1'b1;
                index_d = cnt_q + 9'd2;
              end
            end
          end
          S_CRC: begin
            if (cnt_q == 9'd1) state_d = S_CMD_RX;
            else               cnt_d   = 9'd1;
          end
          default: state_d = S_CMD_RX;
        endcase
      end
    end else if (fall) begin
      // First fall of a byte presents the freshly loaded MSB without shifting.
      if (bit_q == 3'd0) begin
        miso_d = tx_q[7];
      end else begin
        tx_d   = {tx_q[6:0], 1'b1};
        miso_d = tx_q[6];
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state_q <= S_CMD_RX;
      sclk_q  <= '0;
      cs_q    <= 2'b11;
      mosi_q  <= 2'b11;
      rx_q    <= '0;
      tx_q    <= 8'hFF;
      miso_q  <= 1'b1;
      bit_q   <= '0;
      frame_q <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
      r1_q    <= 8'hFF;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      app_q   <= 1'b0;
      retry_q <= '0;
      req_q   <= 1'b0;
      index_q <= '0;
      addr_q  <= '0;
      fetch_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      r1_q    <= r1_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      app_q   <= app_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter INIT_RETRIES, default 3, number of ACMD41 frames answered 0x01 before answering 0x00.
REQ-002 SHALL have parameter READ_GAP, default 2, number of 0xFF bytes between the CMD17 R1 and the 0xFE token.
REQ-003 MasterCLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 SPI_CLK  input  1  host SPI clock, mode 0, asynchronous to MasterCLK.
REQ-006 SPI_CS  input  1  active-low chip select.
REQ-007 SPI_MOSI  input  1  host-to-card serial data, MSB first.
REQ-008 SPI_MISO  output  1  card-to-host serial data, MSB first; driven 1 when idle.
REQ-009 ReadReq  output  1  one-MasterCLK pulse requesting the next block byte.
REQ-010 ReadAddr  output  32  CMD17 argument, latched at command decode.
REQ-011 ReadIndex  output  9  byte index 0..511 within the block, valid with ReadReq.
REQ-012 ReadData  input  8  block byte; sampled exactly 2 MasterCLK cycles after ReadReq.
REQ-013 CardReady  output  1  1 after ACMD41 has completed initialisation.

Function
REQ-014 SPI_CLK, SPI_CS, SPI_MOSI SHALL each pass a 2-flop synchroniser; SPI_CLK edges detected from a third flop; legal SPI_CLK high/low time >= 4 MasterCLK periods.
REQ-015 On detected SPI_CLK rise with SPI_CS low: shift synchronised MOSI into the RX register, increment the 3-bit bit counter.
REQ-016 On detected SPI_CLK fall with SPI_CS low: shift the TX register left, SPI_MISO = TX[7]; after the 8th bit of a byte the next TX byte is loaded so its MSB is on SPI_MISO before the next rise.
REQ-017 States: CMD_RX, NCR, R1, GAP, TOKEN, DATA, CRC.
REQ-018 CMD_RX: TX byte 0xFF; a completed byte with bits[7:6]=01 starts a frame; the following 5 bytes complete it (arg[31:24..7:0], CRC); other bytes are discarded; CRC is not checked.
REQ-019 On frame completion: decode, go NCR (TX 0xFF, one byte), then R1.
REQ-020 R1 values: CMD0 -> 0x01, clears CardReady, app flag and retry count; CMD55 -> 0x01 if not ready else 0x00, sets app flag; ACMD41 (app flag set) -> 0x01 while retry count < INIT_RETRIES (count +1), else 0x00 and CardReady=1; CMD17 with CardReady -> 0x00; CMD17 not ready -> 0x05; any other command -> 0x04 OR (CardReady ? 0x00 : 0x01).
REQ-021 App flag SHALL clear after any frame other than CMD55; CMD41 without app flag is "other command".
REQ-022 After R1: CMD17 with R1=0x00 -> GAP; all others -> CMD_RX.
REQ-023 GAP sends READ_GAP bytes 0xFF; TOKEN sends 0xFE; DATA sends 512 bytes, index 0..511; CRC sends 0xFF, 0xFF; then CMD_RX.
REQ-024 ReadReq pulses at the start of each TX byte preceding a DATA byte (i.e. at load of TOKEN for index 0, at load of data byte n for index n+1), leaving >= 6 bit times before the sampled byte is loaded.
REQ-025 MOSI content SHALL be ignored from NCR through CRC.
REQ-026 SPI_CS high (synchronised) SHALL clear bit counter, force SPI_MISO=1, TX=0xFF, abort any response, return to CMD_RX; CardReady, app flag and retry count are kept.
REQ-027 SPI_CLK edges while SPI_CS high SHALL be ignored.

Reset
REQ-028 On Reset: state CMD_RX, SPI_MISO=1, ReadReq=0, ReadAddr=0, ReadIndex=0, CardReady=0, app flag=0, retry count=0, bit/byte counters=0; Reset mid-block aborts with no further ReadReq.

Verification
REQ-029 CMD0 40 00 00 00 00 95 -> MISO bytes FF (NCR), 01; CardReady=0.
REQ-030 Four CMD55+ACMD41(arg 40000000) pairs -> ACMD41 R1 = 01,01,01,00; CardReady rises after 4th.
REQ-031 After init, CMD17 arg 00001200 -> FF, 00, FF, FF, FE, 512 bytes equal to ReadData for ReadIndex 0..511, FF, FF; ReadAddr=00001200; exactly 512 ReadReq pulses.
REQ-032 CMD17 before init -> R1 05, no token, no ReadReq.
REQ-033 SPI_CS raised after data byte 100 -> MISO=1, no further ReadReq; next CMD58 frame -> R1 04 with CardReady still 1.
REQ-034 Reset asserted mid-DATA -> all outputs at reset values next cycle; CMD17 then answers 05.
